// File: rtl/cr_xp10_decomp_tbl_bank_sched.sv
// Decode-table bank scheduler: htf allocates and fills banks, sdd consumes them
// in allocation order and releases them, with per-bank ownership tracking.
module cr_xp10_decomp_tbl_bank_sched #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int FMT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              htf_tbl_alloc_req,
  output logic              tbl_htf_alloc_gnt,
  output logic [BANK_W-1:0] tbl_htf_alloc_bank,
  input  logic              htf_tbl_done,
  input  logic [FMT_W-1:0]  htf_tbl_done_fmt,
  input  logic              htf_tbl_done_error,
  output logic              tbl_sdd_valid,
  output logic [BANK_W-1:0] tbl_sdd_bank,
  output logic [FMT_W-1:0]  tbl_sdd_fmt,
  output logic              tbl_sdd_error,
  input  logic              sdd_tbl_ready,
  input  logic              sdd_tbl_release,
  input  logic              tbl_flush,
  output logic              tbl_htf_busy,
  output logic [BANK_W:0]   tbl_occupancy,
  output logic              tbl_alloc_stall_stb,
  output logic              tbl_proto_err
);

  // sdd handshake: tbl_sdd_valid/bank/fmt/error are stable until sdd_tbl_ready
  // is seen high with valid at a clock edge; the bank is consumed at that edge.

  typedef enum logic [1:0] {
    BANK_FREE     = 2'd0,
    BANK_WRITING  = 2'd1,
    BANK_READY    = 2'd2,
    BANK_DECODING = 2'd3
  } bank_st_e;

  localparam logic [BANK_W-1:0] PTR_ONE = 1;
  localparam logic [BANK_W:0]   OCC_ONE = 1;

  bank_st_e          state_q [NUM_BANKS];
  bank_st_e          state_d [NUM_BANKS];
  logic [FMT_W-1:0]  fmt_q   [NUM_BANKS];
  logic [FMT_W-1:0]  fmt_d   [NUM_BANKS];
  logic              err_q   [NUM_BANKS];
  logic              err_d   [NUM_BANKS];

  logic [BANK_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BANK_W-1:0] rel_ptr_q, rel_ptr_d;
  logic [BANK_W-1:0] alloc_bank_q, alloc_bank_d;
  logic              gnt_q, gnt_d;
  logic              stall_q, stall_d;
  logic              proto_q, proto_d;

  logic              any_writing;
  logic              grant_ok;
  logic [BANK_W:0]   occ_c;

  always_comb begin
    any_writing = 1'b0;
    occ_c       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (state_q[i] == BANK_WRITING) any_writing = 1'b1;
      if (state_q[i] != BANK_FREE)    occ_c = occ_c + OCC_ONE;
    end
  end

  assign grant_ok = htf_tbl_alloc_req && (state_q[alloc_ptr_q] == BANK_FREE) &&
                    !any_writing && !tbl_flush;

  assign tbl_htf_alloc_gnt   = gnt_q;
  assign tbl_htf_alloc_bank  = alloc_bank_q;
  assign tbl_sdd_valid       = (state_q[rd_ptr_q] == BANK_READY);
  assign tbl_sdd_bank        = rd_ptr_q;
  assign tbl_sdd_fmt         = fmt_q[rd_ptr_q];
  assign tbl_sdd_error       = err_q[rd_ptr_q];
  assign tbl_htf_busy        = (state_q[alloc_ptr_q] != BANK_FREE);
  assign tbl_occupancy       = occ_c;
  assign tbl_alloc_stall_stb = stall_q;
  assign tbl_proto_err       = proto_q;

  // Only one bank can be WRITING, and it is always the last granted one.
  always_comb begin
    state_d      = state_q;
    fmt_d        = fmt_q;
    err_d        = err_q;
    alloc_ptr_d  = alloc_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rel_ptr_d    = rel_ptr_q;
    alloc_bank_d = alloc_bank_q;
    gnt_d        = 1'b0;
    stall_d      = 1'b0;
    proto_d      = proto_q;

    if (tbl_flush) begin
      for (int i = 0; i < NUM_BANKS; i++) state_d[i] = BANK_FREE;
      alloc_ptr_d = '0;
      rd_ptr_d    = '0;
      rel_ptr_d   = '0;
      proto_d     = 1'b0;
    end else begin
      stall_d = htf_tbl_alloc_req && !grant_ok;
      if (grant_ok) begin
        state_d[alloc_ptr_q] = BANK_WRITING;
        gnt_d                = 1'b1;
        alloc_bank_d         = alloc_ptr_q;
        alloc_ptr_d          = alloc_ptr_q + PTR_ONE;
      end
      if (htf_tbl_done) begin
        if (any_writing) begin
          state_d[alloc_bank_q] = BANK_READY;
          fmt_d[alloc_bank_q]   = htf_tbl_done_fmt;
          err_d[alloc_bank_q]   = htf_tbl_done_error;
        end else begin
          proto_d = 1'b1;
        end
      end
      if (tbl_sdd_valid && sdd_tbl_ready) begin
        state_d[rd_ptr_q] = BANK_DECODING;
        rd_ptr_d          = rd_ptr_q + PTR_ONE;
      end
      if (sdd_tbl_release) begin
        if (state_q[rel_ptr_q] == BANK_DECODING) begin
          state_d[rel_ptr_q] = BANK_FREE;
          rel_ptr_d          = rel_ptr_q + PTR_ONE;
        end else begin
          proto_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= BANK_FREE;
        fmt_q[i]   <= '0;
        err_q[i]   <= 1'b0;
      end
      alloc_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      rel_ptr_q    <= '0;
      alloc_bank_q <= '0;
      gnt_q        <= 1'b0;
      stall_q      <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fmt_q        <= fmt_d;
      err_q        <= err_d;
      alloc_ptr_q  <= alloc_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rel_ptr_q    <= rel_ptr_d;
      alloc_bank_q <= alloc_bank_d;
      gnt_q        <= gnt_d;
      stall_q      <= stall_d;
      proto_q      <= proto_d;
    end
  end

endmodule
